apb_slave_ctrl: RTL and testbench



---
 rtl/apb_slave_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb_slave_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_ctrl.sv
// APB3 slave transaction controller: sequences APB transfers into a req/ack back-end handshake.
// Optional error counter (err_count/err_clr) is enabled by defining APB_ERR_CNT_EN.
module apb_slave_ctrl #(
    parameter int                  ADDR_W   = 8,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter int                  TIMEOUT  = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-3:0] reg_idx,
    output logic [31:0]       reg_wdata,
    input  logic              reg_ack,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_err
`ifdef APB_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [7:0]        err_count
`endif
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        prdata_q, prdata_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic               reg_req_q, reg_req_d;
    logic               reg_we_q, reg_we_d;
    logic [IDX_W-1:0]   reg_idx_q, reg_idx_d;
    logic [31:0]        reg_wdata_q, reg_wdata_d;

    logic [IDX_W-1:0]   setup_idx;
    logic [NUM_REGS-1:0] ro_shift;
    logic               decode_err;
    logic               timeout_hit;

    assign setup_idx   = PADDR[ADDR_W-1:2];
    assign ro_shift    = RO_MASK >> setup_idx;
    assign decode_err  = (PADDR[1:0] != 2'b00)
                      || (32'(setup_idx) >= 32'(NUM_REGS))
                      || (PWRITE && ro_shift[0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Response outputs default to zero so PRDATA/PSLVERR can only be nonzero alongside PREADY.
    always_comb begin
        // NOTE: every signal gets a default before the case; a missed branch would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        reg_req_d   = 1'b0;
        reg_we_d    = reg_we_q;
        reg_idx_d   = reg_idx_q;
        reg_wdata_d = reg_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (decode_err) begin
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        reg_req_d   = 1'b1;
                        reg_we_d    = PWRITE;
                        reg_idx_d   = setup_idx;
                        reg_wdata_d = PWDATA;
                        cnt_d       = '0;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = reg_err;
                    prdata_d  = reg_we_q ? '0 : reg_rdata;
                end else if (timeout_hit) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_idx_q   <= reg_idx_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign reg_req   = reg_req_q;
    assign reg_we    = reg_we_q;
    assign reg_idx   = reg_idx_q;
    assign reg_wdata = reg_wdata_q;

`ifdef APB_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Clear has priority over a coincident increment; count saturates at 8'hFF.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (pready_q && pslverr_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Randomized self-checking bench for apb_slave_ctrl against a transfer-level reference model.
// Covers the APB_ERR_CNT_EN counter when that macro is defined for the build.
module tb_apb_slave_ctrl;

    localparam int         ADDR_W   = 8;
    localparam int         NUM_REGS = 8;
    localparam int         TIMEOUT  = 16;
    localparam logic [7:0] RO_MASK  = 8'h01;

    logic              PCLK;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-3:0] reg_idx;
    logic [31:0]       reg_wdata;
    logic              reg_ack;
    logic [31:0]       reg_rdata;
    logic              reg_err;
`ifdef APB_ERR_CNT_EN
    logic              err_clr;
    logic [7:0]        err_count;
`endif

    int n_checks    = 0;
    int n_errors    = 0;
    int exp_err_cnt = 0;

    apb_slave_ctrl #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_idx   (reg_idx),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .reg_err   (reg_err)
`ifdef APB_ERR_CNT_EN
        ,
        .err_clr   (err_clr),
        .err_count (err_count)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic bit model_decode_err(input bit wr, input logic [7:0] addr);
        int idx;
        idx = int'(addr[7:2]);
        if (addr[1:0] != 2'b00) return 1'b1;
        if (idx >= NUM_REGS)    return 1'b1;
        return wr && RO_MASK[idx];
    endfunction

    task automatic note_err_resp();
        if (exp_err_cnt < 255) exp_err_cnt++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  PREADY,  0);
        check({tag, "_slverr"}, PSLVERR, 0);
        check({tag, "_rdata"},  PRDATA,  0);
`ifdef APB_ERR_CNT_EN
        check({tag, "_errcnt"}, err_count, exp_err_cnt);
`endif
    endtask

    // delay = cycles after the reg_req cycle at which the back end acks (large = never).
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input int delay, input logic [31:0] rdata, input bit err);
        bit          acked;
        bit          early;
        int          resp_k;
        logic [31:0] exp_data;
        bit          exp_err;

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        tick();
        PENABLE = 1'b1;

        if (model_decode_err(wr, addr)) begin
            check("derr_no_req", reg_req, 0);
            check("derr_ready",  PREADY,  1);
            check("derr_slverr", PSLVERR, 1);
            check("derr_rdata",  PRDATA,  0);
            note_err_resp();
        end else begin
            check("req_pulse", reg_req,   1);
            check("req_we",    reg_we,    wr);
            check("req_idx",   reg_idx,   addr[7:2]);
            check("req_wdata", reg_wdata, wdata);
            check("req_ready", PREADY,    0);

            acked    = (delay <= TIMEOUT - 1);
            resp_k   = acked ? delay : TIMEOUT - 1;
            exp_data = (acked && !wr) ? rdata : 32'h0;
            exp_err  = acked ? err : 1'b1;
            early    = 1'b0;
            for (int k = 0; k <= resp_k; k++) begin
                reg_ack   = (k == delay);
                reg_rdata = (k == delay) ? rdata : $urandom;
                reg_err   = (k == delay) ? err : 1'($urandom);
                tick();
                if (k < resp_k && (PREADY || PSLVERR || PRDATA != 0)) early = 1'b1;
            end
            reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = $urandom;

            check("no_early_resp", early,     0);
            check("resp_ready",    PREADY,    1);
            check("resp_slverr",   PSLVERR,   exp_err);
            check("resp_rdata",    PRDATA,    exp_data);
            check("held_we",       reg_we,    wr);
            check("held_idx",      reg_idx,   addr[7:2]);
            check("held_wdata",    reg_wdata, wdata);
            check("resp_no_req",   reg_req,   0);
            if (exp_err) note_err_resp();
        end

        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        check_idle("post");
    endtask

    initial begin
        logic [7:0]  addr;
        int          delay;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
`ifdef APB_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_ready",  PREADY,    0);
        check("rst_slverr", PSLVERR,   0);
        check("rst_rdata",  PRDATA,    0);
        check("rst_req",    reg_req,   0);
        check("rst_we",     reg_we,    0);
        check("rst_idx",    reg_idx,   0);
        check("rst_wdata",  reg_wdata, 0);
`ifdef APB_ERR_CNT_EN
        check("rst_errcnt", err_count, 0);
`endif
        PRESET = 1'b0;
        tick();

        // Directed cases from the plan.
        apb_xfer(1'b0, 8'h08, 32'h0, 0, 32'hA5A5_0001, 1'b0);
        apb_xfer(1'b1, 8'h04, 32'h0000_00FF, 3, 32'hDEAD_BEEF, 1'b0);
        apb_xfer(1'b1, 8'h00, 32'h1234_5678, 0, 32'h0, 1'b0);
        apb_xfer(1'b0, 8'h02, 32'h0, 0, 32'h0, 1'b0);
        apb_xfer(1'b0, 8'h20, 32'h0, 0, 32'h0, 1'b0);
        apb_xfer(1'b0, 8'h10, 32'h0, TIMEOUT - 1, 32'hCAFE_0010, 1'b1);
        apb_xfer(1'b0, 8'h0C, 32'h0, 1000, 32'h0, 1'b0);

        // Late ack after a timeout must be ignored.
        reg_ack = 1'b1; reg_rdata = 32'hFFFF_FFFF; reg_err = 1'b1;
        tick();
        reg_ack = 1'b0; reg_err = 1'b0;
        check("late_ack_ready", PREADY,  0);
        check("late_ack_req",   reg_req, 0);
        tick();
        check_idle("late_ack");

        // Reset while waiting on the back end.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h14; PWDATA = 32'h5555_AAAA;
        tick();
        PENABLE = 1'b1;
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        exp_err_cnt = 0;
        check("wrst_ready",  PREADY,    0);
        check("wrst_slverr", PSLVERR,   0);
        check("wrst_rdata",  PRDATA,    0);
        check("wrst_req",    reg_req,   0);
        check("wrst_we",     reg_we,    0);
        check("wrst_idx",    reg_idx,   0);
        check("wrst_wdata",  reg_wdata, 0);
        apb_xfer(1'b0, 8'h00, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

        // Master abort: PSEL dropped during the wait, later ack ignored.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h18;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        check("abort_ready", PREADY, 0);
        reg_ack = 1'b1; reg_rdata = 32'h1111_2222;
        tick();
        reg_ack = 1'b0;
        check("abort_ack_ready", PREADY,  0);
        check("abort_ack_req",   reg_req, 0);
        tick();
        check_idle("abort");
        apb_xfer(1'b1, 8'h1C, 32'h7777_0000, 2, 32'h0, 1'b0);

        // Randomized transfers.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) addr = {3'($urandom_range(0, 7)), 3'b000} >> 1;
            else                           addr = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) delay = $urandom_range(10, 24);
            else                           delay = $urandom_range(0, 4);
            apb_xfer(1'($urandom), addr, $urandom, delay, $urandom, ($urandom_range(0, 5) == 0));
        end

`ifdef APB_ERR_CNT_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err_cnt = 0;
        check("cnt_clr0", err_count, 0);
        for (int n = 0; n < 300; n++) apb_xfer(1'b0, 8'h02, 32'h0, 0, 32'h0, 1'b0);
        check("cnt_sat", err_count, 8'hFF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err_cnt = 0;
        check("cnt_clr1", err_count, 0);
        // Clear coincident with an error response.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h21;
        tick();
        PENABLE = 1'b1;
        check("coinc_ready", PREADY, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        check("coinc_clr", err_count, 0);
        tick();
        check("coinc_after", err_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
